// File: rtl/dd_data_tx.sv
// dd_data_tx: framed, odd-parity serial transmitter for the 36-bit data link.
// Accepts words on a valid/ready handshake, with one hold buffer ahead of the shifter.
module dd_data_tx #(
   parameter int GAP_BITS = 2
) (
   input  logic        clk,
   input  logic        res_n,
   input  logic [35:0] din,
   input  logic        validin,
   output logic        readyin,
   output logic        d_tr,
   output logic        busy
);
   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, GAP} state_t;
   localparam logic [3:0] GAP_LAST = 4'(GAP_BITS - 1);
   state_t      state_q, state_d;
   logic [35:0] hold_q, hold_d, shift_q, shift_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [3:0]  gap_q, gap_d;
   logic        hold_full_q, hold_full_d, par_q, par_d;
   logic        d_tr_q, d_tr_d, ready_q, ready_d, busy_q, busy_d;
   logic        accept, load, last_gap;
   always_comb begin
      accept   = validin & ready_q;
      load     = 1'b0;
      last_gap = 1'b0;
      state_d  = state_q;
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      gap_d    = gap_q;
      par_d    = par_q;
      d_tr_d   = 1'b0;
      case (state_q)
         IDLE:  load = hold_full_q;
         START: begin
            d_tr_d  = shift_q[35];
            shift_d = {shift_q[34:0], 1'b0};
            cnt_d   = 6'd35;
            state_d = DATA;
         end
         DATA: begin
            d_tr_d  = (cnt_q == 6'd0) ? par_q : shift_q[35];
            shift_d = {shift_q[34:0], 1'b0};
            cnt_d   = (cnt_q == 6'd0) ? 6'd0 : cnt_q - 6'd1;
            state_d = (cnt_q == 6'd0) ? PAR : DATA;
         end
         PAR:  state_d = STOP;
         STOP: begin
            last_gap = (GAP_BITS == 0);
            gap_d    = GAP_LAST;
            state_d  = GAP;
         end
         GAP: begin
            last_gap = (gap_q == 4'd0);
            gap_d    = (gap_q == 4'd0) ? 4'd0 : gap_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase
      // The final gap cycle either chains straight into the next frame or idles the line.
      if (last_gap) begin
         load    = hold_full_q;
         state_d = IDLE;
      end
      if (load) begin
         shift_d = hold_q;
         par_d   = ~^hold_q;
         d_tr_d  = 1'b1;
         state_d = START;
      end
      hold_d      = accept ? din : hold_q;
      hold_full_d = accept ? 1'b1 : (load ? 1'b0 : hold_full_q);
      ready_d     = ~hold_full_d;
      busy_d      = (state_d != IDLE) | hold_full_d;
   end
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         shift_q     <= '0;
         cnt_q       <= '0;
         gap_q       <= '0;
         hold_full_q <= 1'b0;
         par_q       <= 1'b0;
         d_tr_q      <= 1'b0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         gap_q       <= gap_d;
         hold_full_q <= hold_full_d;
         par_q       <= par_d;
         d_tr_q      <= d_tr_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
      end
   end
   assign readyin = ready_q;
   assign d_tr    = d_tr_q;
   assign busy    = busy_q;
endmodule

// File: tb/tb_dd_data_tx.sv
// tb_dd_data_tx: checks dd_data_tx with GAP_BITS=2 (index 0) and GAP_BITS=0 (index 1)
// against a frame-schedule reference model, plus table vectors and corner sequences.
module tb_dd_data_tx;
   typedef struct {
      logic [35:0] w;
      logic        p;
      logic        s;
      int          t;
   } frame_t;
   typedef struct {
      logic [35:0] w;
      logic        p;
   } vec_t;
   logic             clk = 1'b0;
   logic             res_n = 1'b0;
   logic [1:0]       validin, readyin, d_tr, busy;
   logic [1:0][35:0] din;
   dd_data_tx #(.GAP_BITS(2)) dut_g2 (.clk(clk), .res_n(res_n), .din(din[0]), .validin(validin[0]),
      .readyin(readyin[0]), .d_tr(d_tr[0]), .busy(busy[0]));
   dd_data_tx #(.GAP_BITS(0)) dut_g0 (.clk(clk), .res_n(res_n), .din(din[1]), .validin(validin[1]),
      .readyin(readyin[1]), .d_tr(d_tr[1]), .busy(busy[1]));
   always #5 clk = ~clk;
   int n_chk = 0, n_fail = 0, cyc = 0;
   int nfr [2] = '{0, 0};
   frame_t fr [2][16];
   logic [1:0]       pend_v = '0, rdy_m = '0, sv;
   logic [1:0][35:0] pend_w = '0, cur_w = '0, sd;
   int pend_s [2] = '{0, 0};
   int cur_s [2] = '{-1000, -1000};
   int last_end [2] = '{-1000, -1000};
   function automatic int gap_of(int i);
      return (i == 0) ? 2 : 0;
   endfunction
   // Line level j cycles after a frame's start edge: start, MSB-first data, odd parity, stop.
   function automatic logic exp_bit(logic [35:0] w, int j);
      if (j == 0) return 1'b1;
      if (j >= 1 && j <= 36) return w[36-j];
      if (j == 37) return ~^w;
      return 1'b0;
   endfunction
   task automatic check(string name, int i, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, i, cyc, got, exp);
      end
   endtask
   // Reference model: each word starts at max(accept+1, end of previous frame + gap).
   initial forever begin
      @(posedge clk);
      sv = validin;
      sd = din;
      cyc++;
      #1;
      for (int i = 0; i < 2; i++) begin
         if (!res_n) begin
            pend_v[i] = 1'b0;
            rdy_m[i] = 1'b0;
            cur_s[i] = -1000;
            last_end[i] = -1000;
         end else begin
            if (sv[i] && rdy_m[i]) begin
               pend_v[i] = 1'b1;
               pend_w[i] = sd[i];
               pend_s[i] = (cyc + 1 > last_end[i]) ? cyc + 1 : last_end[i];
            end
            if (pend_v[i] && pend_s[i] == cyc) begin
               cur_w[i] = pend_w[i];
               cur_s[i] = cyc;
               last_end[i] = cyc + 39 + gap_of(i);
               pend_v[i] = 1'b0;
            end
            rdy_m[i] = ~pend_v[i];
         end
         check("model_d_tr", i, 64'(d_tr[i]), 64'(exp_bit(cur_w[i], cyc - cur_s[i])));
         check("model_readyin", i, 64'(readyin[i]), 64'(rdy_m[i]));
         check("model_busy", i, 64'(busy[i]), 64'(pend_v[i] | (cyc < last_end[i])));
      end
   end
   // Line decoder: collects complete frames seen on d_tr.
   initial begin
      int b [2];
      frame_t cur [2];
      b = '{0, 0};
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (!res_n) b[i] = 0;
            else if (b[i] == 0) begin
               if (d_tr[i]) begin
                  b[i] = 1;
                  cur[i].t = cyc;
                  cur[i].w = '0;
               end
            end else begin
               if (b[i] <= 36) cur[i].w = {cur[i].w[34:0], d_tr[i]};
               else if (b[i] == 37) cur[i].p = d_tr[i];
               else begin
                  cur[i].s = d_tr[i];
                  if (nfr[i] < 16) fr[i][nfr[i]] = cur[i];
                  nfr[i]++;
               end
               b[i] = (b[i] == 38) ? 0 : b[i] + 1;
            end
         end
      end
   end
   task automatic send(int i, logic [35:0] w);
      int k = 0;
      logic r;
      din[i] = w;
      validin[i] = 1'b1;
      r = rdy_m[i];
      while (!r && k < 200) begin
         @(negedge clk);
         r = rdy_m[i];
         k++;
      end
      if (!r) check("accept_timeout", i, 64'(r), 64'(1));
      @(negedge clk);
   endtask
   task automatic wait_frames(int i, int n);
      int k = 0;
      while (nfr[i] < n && k < 400) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("frame_count", i, 64'(nfr[i]), 64'(n));
   endtask
   task automatic idle(int n);
      validin = '0;
      repeat (n) @(negedge clk);
   endtask
   initial begin
      vec_t vt [6];
      logic [35:0] ws [3];
      int k;
      validin = '0;
      din = '0;
      vt[0] = '{36'h000000001, 1'b0};
      vt[1] = '{36'h000000000, 1'b1};
      vt[2] = '{36'hFFFFFFFFF, 1'b1};
      vt[3] = '{36'h7FFFFFFFF, 1'b0};
      vt[4] = '{36'hA5A5A5A5A, 1'b1};
      vt[5] = '{36'h800000000, 1'b0};
      #3;
      for (int i = 0; i < 2; i++) begin
         check("reset_d_tr", i, 64'(d_tr[i]), 64'(0));
         check("reset_readyin", i, 64'(readyin[i]), 64'(0));
         check("reset_busy", i, 64'(busy[i]), 64'(0));
      end
      repeat (3) @(negedge clk);
      res_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 2; i++) check("ready_after_reset", i, 64'(readyin[i]), 64'(1));
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            check("idle_d_tr", i, 64'(d_tr[i]), 64'(0));
            check("idle_readyin", i, 64'(readyin[i]), 64'(1));
            check("idle_busy", i, 64'(busy[i]), 64'(0));
         end
      end
      for (int v = 0; v < 6; v++) begin
         nfr[0] = 0;
         send(0, vt[v].w);
         validin[0] = 1'b0;
         wait_frames(0, 1);
         check("tbl_word", 0, 64'(fr[0][0].w), 64'(vt[v].w));
         check("tbl_parity", 0, 64'(fr[0][0].p), 64'(vt[v].p));
         check("tbl_stop", 0, 64'(fr[0][0].s), 64'(0));
         if (v == 0) begin
            @(negedge clk);
            check("busy_gap1", 0, 64'(busy[0]), 64'(1));
            @(negedge clk);
            check("busy_gap2", 0, 64'(busy[0]), 64'(1));
            @(negedge clk);
            check("busy_drop", 0, 64'(busy[0]), 64'(0));
         end
         idle(5);
      end
      for (int i = 0; i < 2; i++) begin
         idle(50);
         nfr[i] = 0;
         for (int j = 0; j < 3; j++) ws[j] = {4'($urandom), $urandom};
         for (int j = 0; j < 3; j++) send(i, ws[j]);
         check("b2b_ready_low", i, 64'(readyin[i]), 64'(0));
         check("b2b_busy", i, 64'(busy[i]), 64'(1));
         validin[i] = 1'b0;
         wait_frames(i, 3);
         for (int j = 0; j < 3; j++) check("b2b_word", i, 64'(fr[i][j].w), 64'(ws[j]));
         check("b2b_space1", i, 64'(fr[i][1].t - fr[i][0].t), 64'(39 + gap_of(i)));
         check("b2b_space2", i, 64'(fr[i][2].t - fr[i][1].t), 64'(39 + gap_of(i)));
      end
      idle(50);
      nfr[0] = 0;
      send(0, 36'h0F0F0F0F0);
      send(0, 36'hCAFEBABE1);
      check("bp_ready_low", 0, 64'(readyin[0]), 64'(0));
      din[0] = 36'h123456789;
      validin[0] = 1'b1;
      repeat (2) @(negedge clk);
      validin[0] = 1'b0;
      wait_frames(0, 2);
      idle(100);
      check("bp_frames", 0, 64'(nfr[0]), 64'(2));
      check("bp_word0", 0, 64'(fr[0][0].w), 64'(36'h0F0F0F0F0));
      check("bp_word1", 0, 64'(fr[0][1].w), 64'(36'hCAFEBABE1));
      idle(50);
      nfr[0] = 0;
      send(0, 36'hFFFFFFFFF);
      validin[0] = 1'b0;
      k = 0;
      while (!d_tr[0] && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("mid_start_seen", 0, 64'(d_tr[0]), 64'(1));
      repeat (16) @(negedge clk);
      check("mid_bit20", 0, 64'(d_tr[0]), 64'(1));
      #2 res_n = 1'b0;
      #1;
      check("mid_reset_d_tr", 0, 64'(d_tr[0]), 64'(0));
      check("mid_reset_readyin", 0, 64'(readyin[0]), 64'(0));
      check("mid_reset_busy", 0, 64'(busy[0]), 64'(0));
      repeat (3) @(negedge clk);
      res_n = 1'b1;
      @(negedge clk);
      nfr[0] = 0;
      send(0, 36'hA5A5A5A5A);
      validin[0] = 1'b0;
      wait_frames(0, 1);
      check("post_reset_word", 0, 64'(fr[0][0].w), 64'(36'hA5A5A5A5A));
      check("post_reset_parity", 0, 64'(fr[0][0].p), 64'(1));
      idle(60);
      check("post_reset_frames", 0, 64'(nfr[0]), 64'(1));
      for (int i = 0; i < 2; i++)
         for (int n = 0; n < 30; n++) begin
            idle($urandom_range(0, 45));
            send(i, {4'($urandom), $urandom});
            if ($urandom_range(0, 3) == 0) send(i, {4'($urandom), $urandom});
            validin[i] = 1'b0;
         end
      idle(120);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
